// File: rtl/timer_pkg.sv
// Shared constants for the timer controller: register map, CTRL bit positions
// and FSM state encoding.
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LOAD   = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int EN        = 0;
  localparam int PERIODIC  = 1;
  localparam int IRQ_EN    = 2;
  localparam int PRESC_LSB = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: emits a one-cycle tick every presc+1 clocks while run is high;
// holds its count when run is low, clr forces it back to 0.
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] presc,
  input  logic               run,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == presc);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (run) cnt_d = tick ? '0 : cnt_q + PRESC_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_toggle.sv
// Toggle-divider primitive: q inverts on every clock where en is high.
module timer_toggle (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic q
);

  logic q_q, q_d;

  assign q_d = en ? ~q_q : q_q;
  assign q   = q_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= 1'b0;
    else      q_q <= q_d;
  end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable down-counting timer with one-shot/periodic modes and maskable irq.
// Define TIMER_CTRL_TOGGLE_OUT_EN to add the tout square-wave output.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rd_valid,
  output logic        irq,
  output logic        busy
`ifdef TIMER_CTRL_TOGGLE_OUT_EN
  ,output logic       tout
`endif
);

  state_e             state_q, state_d;
  logic               en_q, en_d;
  logic               periodic_q, periodic_d;
  logic               irq_en_q, irq_en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   load_q, load_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               expired_q, expired_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rd_valid_q, rd_valid_d;

  logic wr_ctrl, wr_load, wr_status, stop_wr;
  logic presc_run, presc_clr, tick, expire;
  logic [31:0] ctrl_rd, count_rd;

  assign wr_ctrl   = wr_en && (addr == ADDR_CTRL);
  assign wr_load   = wr_en && (addr == ADDR_LOAD);
  assign wr_status = wr_en && (addr == ADDR_STATUS);
  // A disabling write freezes everything this cycle, including a coincident tick.
  assign stop_wr   = wr_ctrl && !wdata[EN];
  assign presc_run = (state_q == RUN) && !stop_wr;
  assign expire    = tick && (count_q == '0);

  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .presc (presc_q),
    .run   (presc_run),
    .clr   (presc_clr),
    .tick  (tick)
  );

  always_comb begin
    ctrl_rd                         = '0;
    ctrl_rd[EN]                     = en_q;
    ctrl_rd[PERIODIC]               = periodic_q;
    ctrl_rd[IRQ_EN]                 = irq_en_q;
    ctrl_rd[PRESC_LSB +: PRESC_W]   = presc_q;
    count_rd                        = '0;
    count_rd[CNT_W-1:0]             = count_q;
  end

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    presc_d    = presc_q;
    load_d     = load_q;
    count_d    = count_q;
    expired_d  = expired_q;
    presc_clr  = 1'b0;

    if (wr_ctrl) begin
      en_d       = wdata[EN];
      periodic_d = wdata[PERIODIC];
      irq_en_d   = wdata[IRQ_EN];
      presc_d    = wdata[PRESC_LSB +: PRESC_W];
    end
    if (wr_load) load_d = wdata[CNT_W-1:0];
    if (wr_status && wdata[0]) expired_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (wr_ctrl && wdata[EN]) begin
          count_d   = load_q;
          presc_clr = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (stop_wr) begin
          state_d = IDLE;
        end else if (expire) begin
          // Hardware set is applied after the W1C so it wins a collision.
          expired_d = 1'b1;
          if (periodic_q) begin
            count_d = load_q;
          end else begin
            en_d    = 1'b0;
            state_d = DONE;
          end
        end else if (tick) begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_valid_d = rd_en;
    rdata_d    = rdata_q;
    if (rd_en) begin
      case (addr)
        ADDR_CTRL:   rdata_d = ctrl_rd;
        ADDR_LOAD:   rdata_d = 32'(load_q);
        ADDR_COUNT:  rdata_d = count_rd;
        default:     rdata_d = {31'b0, expired_q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      presc_q    <= '0;
      load_q     <= '0;
      count_q    <= '0;
      expired_q  <= 1'b0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      presc_q    <= presc_d;
      load_q     <= load_d;
      count_q    <= count_d;
      expired_q  <= expired_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
  assign irq      = expired_q & irq_en_q;
  assign busy     = (state_q == RUN);

`ifdef TIMER_CTRL_TOGGLE_OUT_EN
  timer_toggle u_tog (
    .clk (clk),
    .rst (rst),
    .en  (expire && presc_run),
    .q   (tout)
  );
`endif

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Programmable down-counting timer controller for the SimpleRISC SoC, built around the toggle-divider timer primitive.
- Sequences a prescaler and a 32-bit down-counter.
- Supports one-shot and periodic modes, and raises a maskable interrupt line to the core.
- Configured by the core through a small word-addressed register port on the peripheral bus.

Parameters:
CNT_W, 32, counter and LOAD register width
PRESC_W, 8, prescaler divide-value width (CTRL[15:8])

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
wr_en  input  1  register write strobe, one cycle
rd_en  input  1  register read strobe, one cycle
addr  input  2  register select: 0 CTRL, 1 LOAD, 2 COUNT (RO), 3 STATUS
wdata  input  32  write data
rdata  output  32  read data, registered
rd_valid  output  1  high one cycle after rd_en
irq  output  1  interrupt = STATUS.expired & CTRL.irq_en
busy  output  1  high in RUN state

Behaviour:
- Reset (rst=0, async):
  - CTRL, LOAD, COUNT, STATUS, prescaler count = 0; state IDLE.
  - rdata=0, rd_valid=0, irq=0, busy=0.
- CTRL fields:
  - bit0 en, bit1 periodic, bit2 irq_en.
  - [15:8] presc: tick every presc+1 clocks.
  - Other bits read 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - A CTRL write with en=1 loads COUNT<=LOAD and clears the prescaler; next state RUN.
  - A write with en=0 stays in IDLE.
- RUN:
  - The prescaler increments each clock; tick when prescaler==presc, then the prescaler wraps to 0.
  - On tick with COUNT!=0: COUNT<=COUNT-1.
  - On tick with COUNT==0:
    - Set STATUS.expired.
    - If periodic: COUNT<=LOAD, stay in RUN.
    - Else: clear CTRL.en, go to DONE.
  - LOAD=0, periodic: expires on every tick.
- DONE:
  - COUNT holds 0; busy=0.
  - A CTRL write with en=1 restarts exactly as from IDLE.
- Write en=0 in RUN: go to IDLE next cycle; COUNT and prescaler freeze; a tick coincident with the write is discarded.
- Write en=1 in RUN: does not restart. Only presc, periodic and irq_en update.
- LOAD write in RUN: no effect on COUNT until the next reload or restart.
- COUNT writes are ignored.
- STATUS:
  - bit0 expired, sticky; write-1-to-clear.
  - A hardware set in the same cycle as a software clear: the set wins (bit stays 1).
- Reads:
  - rdata is updated the cycle after rd_en, with rd_valid=1 for that one cycle.
  - The read returns the value before any same-cycle write.
  - Simultaneous wr_en and rd_en are both honoured.
- irq is combinational from registered STATUS.expired and CTRL.irq_en. No glitch source beyond the flops.
- Counter arithmetic is modulo 2^CNT_W; underflow never occurs because 0 triggers reload or stop.

Optional Feature:
Macro TIMER_CTRL_TOGGLE_OUT_EN.
- Defined:
  - Extra output port tout (1 bit), reset 0, which toggles on every expiry event.
  - A square wave of period 2*(LOAD+1)*(presc+1) clocks in periodic mode.
  - Implemented by instantiating the toggle flop clocked by clk, gated by an expiry enable.
- Undefined: port absent, no extra logic.

Decomposition:
- Shared package timer_pkg:
  - Register address constants (ADDR_CTRL=0, ADDR_LOAD=1, ADDR_COUNT=2, ADDR_STATUS=3).
  - CTRL bit-position constants (EN=0, PERIODIC=1, IRQ_EN=2, PRESC_LSB=8).
  - State encoding (IDLE=0, RUN=1, DONE=2).
- One natural sub-module: timer_prescaler. Inputs: presc value, run enable, clear. Output: one-cycle tick.
- Register file, FSM and counter stay in timer_ctrl.

Test Plan:
- Reset mid-RUN:
  - Stimulus: LOAD=100, CTRL=0x1; after 20 cycles assert rst=0 for 1 cycle.
  - Required: COUNT=0, state IDLE, irq=0 and busy=0 immediately (asynchronous).
- One-shot:
  - Stimulus: LOAD=3, presc=0, CTRL=0x5 at cycle 0.
  - Required: STATUS.expired=1 and irq=1 at tick 4 (cycle 5); busy=0; CTRL reads 0x4.
- Periodic with prescaler:
  - Stimulus: LOAD=2, presc=1, CTRL=0x0103.
  - Required: expiry every 6 clocks; COUNT sequence 2,2,1,1,0,0,2.
  - With the macro defined: tout toggles every 6 clocks.
- Clear/set collision:
  - Stimulus: in periodic mode with LOAD=0 and presc=0, write STATUS=1 in the cycle of an expiry.
  - Required: expired stays 1.
- Disable and LOAD update in RUN:
  - Stimulus: write LOAD=9 mid-count; later write CTRL.en=0.
  - Required: COUNT continues its old sequence; it then freezes and IDLE is entered.
  - A subsequent en=1 write loads 9.
- Read latency:
  - Stimulus: rd_en with addr=2 while running.
  - Required: rd_valid exactly 1 cycle later; rdata = COUNT sampled at the rd_en cycle.
